// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: ALU codes,
// opcode/func constants, FSM state encoding, mux selects and decode types.
package mc_control_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [1:0] A_PC      = 2'd0;
  localparam logic [1:0] A_RS      = 2'd1;
  localparam logic [1:0] A_SHAMT   = 2'd2;

  localparam logic [1:0] B_RT      = 2'd0;
  localparam logic [1:0] B_FOUR    = 2'd1;
  localparam logic [1:0] B_SEXT    = 2'd2;
  localparam logic [1:0] B_BR      = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT     = 2'd0;
  localparam logic [1:0] RD_RD     = 2'd1;
  localparam logic [1:0] RD_R31    = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  typedef enum logic [3:0] {
    CL_RALU = 4'd0,
    CL_IALU = 4'd1,
    CL_LW   = 4'd2,
    CL_SW   = 4'd3,
    CL_BEQ  = 4'd4,
    CL_BNE  = 4'd5,
    CL_J    = 4'd6,
    CL_JAL  = 4'd7,
    CL_JR   = 4'd8,
    CL_ILL  = 4'd9
  } iclass_t;

  typedef struct packed {
    iclass_t    iclass;
    logic [3:0] aluc;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       ext_zero;
    logic       illegal;
  } decode_t;

  typedef struct packed {
    logic [3:0] aluc;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       ext_zero;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

  function automatic logic branch_taken(input iclass_t iclass, input logic z);
    return ((iclass == CL_BEQ) && z) || ((iclass == CL_BNE) && !z);
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational instruction decoder: op/func to instruction class, the
// EXE-state ALU operation and operand selects, and the illegal flag.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output decode_t    dec
);

  // op/func lookup; anything not listed falls through to the illegal class
  always_comb begin
    dec.iclass   = CL_ILL;
    dec.aluc     = ALUC_ADD;
    dec.a_sel    = A_RS;
    dec.b_sel    = B_RT;
    dec.ext_zero = 1'b0;
    if (op == OP_RTYPE) begin
      case (func)
        FN_ADD: begin dec.iclass = CL_RALU; dec.aluc = ALUC_ADD; end
        FN_SUB: begin dec.iclass = CL_RALU; dec.aluc = ALUC_SUB; end
        FN_AND: begin dec.iclass = CL_RALU; dec.aluc = ALUC_AND; end
        FN_OR:  begin dec.iclass = CL_RALU; dec.aluc = ALUC_OR;  end
        FN_XOR: begin dec.iclass = CL_RALU; dec.aluc = ALUC_XOR; end
        FN_SLL: begin dec.iclass = CL_RALU; dec.aluc = ALUC_SLL; dec.a_sel = A_SHAMT; end
        FN_SRL: begin dec.iclass = CL_RALU; dec.aluc = ALUC_SRL; dec.a_sel = A_SHAMT; end
        FN_SRA: begin dec.iclass = CL_RALU; dec.aluc = ALUC_SRA; dec.a_sel = A_SHAMT; end
        FN_JR:  begin dec.iclass = CL_JR; end
        default: begin dec.iclass = CL_ILL; end
      endcase
    end else begin
      case (op)
        OP_ADDI: begin dec.iclass = CL_IALU; dec.b_sel = B_SEXT; end
        OP_ANDI: begin
          dec.iclass = CL_IALU; dec.aluc = ALUC_AND; dec.b_sel = B_SEXT; dec.ext_zero = 1'b1;
        end
        OP_ORI: begin
          dec.iclass = CL_IALU; dec.aluc = ALUC_OR; dec.b_sel = B_SEXT; dec.ext_zero = 1'b1;
        end
        OP_XORI: begin
          dec.iclass = CL_IALU; dec.aluc = ALUC_XOR; dec.b_sel = B_SEXT; dec.ext_zero = 1'b1;
        end
        OP_LUI:  begin dec.iclass = CL_IALU; dec.aluc = ALUC_LUI; dec.b_sel = B_SEXT; end
        OP_LW:   begin dec.iclass = CL_LW;  dec.b_sel = B_SEXT; end
        OP_SW:   begin dec.iclass = CL_SW;  dec.b_sel = B_SEXT; end
        OP_BEQ:  begin dec.iclass = CL_BEQ; dec.aluc = ALUC_SUB; end
        OP_BNE:  begin dec.iclass = CL_BNE; dec.aluc = ALUC_SUB; end
        OP_J:    begin dec.iclass = CL_J;   end
        OP_JAL:  begin dec.iclass = CL_JAL; end
        default: begin dec.iclass = CL_ILL; end
      endcase
    end
    dec.illegal = (dec.iclass == CL_ILL);
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB) for the MIPS-subset CPU with a
// shared instruction/data memory handshaking on mem_ready.
module mc_control
  import mc_control_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic [3:0] aluc,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       ext_zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       illegal
);

  state_t  state_r;
  state_t  state_next_s;
  decode_t dec_s;
  ctrl_t   ctrl_s;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .dec  (dec_s)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = ST_IF;
    case (state_r)
      ST_IF: begin
        if (mem_ready) state_next_s = ST_ID;
        else           state_next_s = ST_IF;
      end
      ST_ID: begin
        case (dec_s.iclass)
          CL_J, CL_JAL, CL_JR, CL_ILL: state_next_s = ST_IF;
          default:                     state_next_s = ST_EXE;
        endcase
      end
      ST_EXE: begin
        case (dec_s.iclass)
          CL_LW, CL_SW:   state_next_s = ST_MEM;
          CL_BEQ, CL_BNE: state_next_s = ST_IF;
          default:        state_next_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)                   state_next_s = ST_MEM;
        else if (dec_s.iclass == CL_LW)   state_next_s = ST_WB;
        else                              state_next_s = ST_IF;
      end
      ST_WB:   state_next_s = ST_IF;
      default: state_next_s = ST_IF;
    endcase
  end

  // Per-state output decode; everything is forced low while reset is held
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      ST_IF: begin
        ctrl_s.aluc      = ALUC_ADD;
        ctrl_s.alu_a_sel = A_PC;
        ctrl_s.alu_b_sel = B_FOUR;
        ctrl_s.mem_read  = 1'b1;
        if (mem_ready) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          ctrl_s.pc_src   = PC_ALU;
        end else begin
          ctrl_s.ir_write = 1'b0;
          ctrl_s.pc_write = 1'b0;
        end
      end
      ST_ID: begin
        ctrl_s.aluc      = ALUC_ADD;
        ctrl_s.alu_a_sel = A_PC;
        ctrl_s.alu_b_sel = B_BR;
        case (dec_s.iclass)
          CL_J: begin
            ctrl_s.pc_write = 1'b1;
            ctrl_s.pc_src   = PC_JUMP;
          end
          CL_JAL: begin
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_src    = PC_JUMP;
            ctrl_s.reg_write = 1'b1;
            ctrl_s.reg_dst   = RD_R31;
            ctrl_s.wb_sel    = WB_PC;
          end
          CL_JR: begin
            ctrl_s.pc_write = 1'b1;
            ctrl_s.pc_src   = PC_RS;
          end
          CL_ILL:  ctrl_s.illegal = 1'b1;
          default: ctrl_s.illegal = 1'b0;
        endcase
      end
      ST_EXE: begin
        ctrl_s.aluc      = dec_s.aluc;
        ctrl_s.alu_a_sel = dec_s.a_sel;
        ctrl_s.alu_b_sel = dec_s.b_sel;
        ctrl_s.ext_zero  = dec_s.ext_zero;
        // branch target was left in ALUOut by ID
        if (branch_taken(dec_s.iclass, z)) begin
          ctrl_s.pc_write = 1'b1;
          ctrl_s.pc_src   = PC_ALUOUT;
        end else begin
          ctrl_s.pc_write = 1'b0;
        end
      end
      ST_MEM: begin
        ctrl_s.iord      = 1'b1;
        ctrl_s.mem_read  = (dec_s.iclass == CL_LW);
        ctrl_s.mem_write = (dec_s.iclass == CL_SW);
      end
      ST_WB: begin
        ctrl_s.reg_write = 1'b1;
        case (dec_s.iclass)
          CL_RALU: ctrl_s.reg_dst = RD_RD;
          CL_LW:   ctrl_s.wb_sel  = WB_MDR;
          default: ctrl_s.reg_dst = RD_RT;
        endcase
      end
      default: ctrl_s = '0;
    endcase
    if (!resetn) begin
      ctrl_s = '0;
    end else begin
      ctrl_s = ctrl_s;
    end
  end

  assign aluc      = ctrl_s.aluc;
  assign alu_a_sel = ctrl_s.alu_a_sel;
  assign alu_b_sel = ctrl_s.alu_b_sel;
  assign ext_zero  = ctrl_s.ext_zero;
  assign mem_read  = ctrl_s.mem_read;
  assign mem_write = ctrl_s.mem_write;
  assign iord      = ctrl_s.iord;
  assign ir_write  = ctrl_s.ir_write;
  assign pc_write  = ctrl_s.pc_write;
  assign pc_src    = ctrl_s.pc_src;
  assign reg_write = ctrl_s.reg_write;
  assign reg_dst   = ctrl_s.reg_dst;
  assign wb_sel    = ctrl_s.wb_sel;
  assign illegal   = ctrl_s.illegal;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected control words are
// generated from the instruction-level timing rules and compared every cycle.
module tb_mc_control;

  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] op, func;
  logic       z, mem_ready;
  logic [3:0] aluc;
  logic [1:0] alu_a_sel, alu_b_sel, pc_src, reg_dst, wb_sel;
  logic       ext_zero, mem_read, mem_write, iord, ir_write, pc_write, reg_write, illegal;

  mc_control dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .aluc(aluc), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .ext_zero(ext_zero),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .illegal(illegal)
  );

  always #5 clock = ~clock;

  logic [21:0] obs;
  assign obs = {aluc, alu_a_sel, alu_b_sel, ext_zero, mem_read, mem_write, iord,
                ir_write, pc_write, pc_src, reg_write, reg_dst, wb_sel, illegal};

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

  logic [21:0] exp_q[$];
  logic        mr_q[$];
  logic        z_q[$];
  string       tag_q[$];

  logic [5:0] op_tab [11] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b100011,
                              6'b101011, 6'b000100, 6'b000101, 6'b001111, 6'b000010, 6'b000011};
  logic [5:0] fn_tab [9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                              6'b000000, 6'b000010, 6'b000011, 6'b001000};

  function automatic logic [21:0] mk(input logic [3:0] ac, input logic [1:0] as_, input logic [1:0] bs,
                                     input logic ez, input logic mr, input logic mw, input logic io,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] wb,
                                     input logic il);
    return {ac, as_, bs, ez, mr, mw, io, irw, pcw, pcs, rw, rd, wb, il};
  endfunction

  task automatic check(input string tag, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    assert (act === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [21:0] e, input logic mr, input logic zz, input string t);
    exp_q.push_back(e);
    mr_q.push_back(mr);
    z_q.push_back(zz);
    tag_q.push_back(t);
  endtask

  // Expected per-cycle control words for one instruction, from the timing rules
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic zz,
                       input int ifw, input int mw, input string name);
    int k = K_ILL;
    logic [3:0] ac = 4'b0000;
    logic [1:0] as_ = 2'd1;
    logic [1:0] bs = 2'd0;
    logic ez = 1'b0;
    logic tk;
    logic [21:0] e;
    op = o;
    func = f;
    if (o == 6'b000000) begin
      case (f)
        6'b100000: begin k = K_R; ac = 4'b0000; end
        6'b100010: begin k = K_R; ac = 4'b0100; end
        6'b100100: begin k = K_R; ac = 4'b0001; end
        6'b100101: begin k = K_R; ac = 4'b0101; end
        6'b100110: begin k = K_R; ac = 4'b0010; end
        6'b000000: begin k = K_R; ac = 4'b0011; as_ = 2'd2; end
        6'b000010: begin k = K_R; ac = 4'b0111; as_ = 2'd2; end
        6'b000011: begin k = K_R; ac = 4'b1111; as_ = 2'd2; end
        6'b001000: k = K_JR;
        default:   k = K_ILL;
      endcase
    end else begin
      case (o)
        6'b001000: begin k = K_I; bs = 2'd2; end
        6'b001100: begin k = K_I; ac = 4'b0001; bs = 2'd2; ez = 1'b1; end
        6'b001101: begin k = K_I; ac = 4'b0101; bs = 2'd2; ez = 1'b1; end
        6'b001110: begin k = K_I; ac = 4'b0010; bs = 2'd2; ez = 1'b1; end
        6'b001111: begin k = K_I; ac = 4'b0110; bs = 2'd2; end
        6'b100011: begin k = K_LW; bs = 2'd2; end
        6'b101011: begin k = K_SW; bs = 2'd2; end
        6'b000100: begin k = K_BEQ; ac = 4'b0100; end
        6'b000101: begin k = K_BNE; ac = 4'b0100; end
        6'b000010: k = K_J;
        6'b000011: k = K_JAL;
        default:   k = K_ILL;
      endcase
    end
    for (int i = 0; i < ifw; i++)
      push(mk(4'd0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0),
           1'b0, 1'($urandom_range(0, 1)), {name, "/IFwait"});
    push(mk(4'd0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0),
         1'b1, 1'($urandom_range(0, 1)), {name, "/IF"});
    case (k)
      K_J:     e = mk(4'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0);
      K_JAL:   e = mk(4'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0);
      K_JR:    e = mk(4'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0);
      K_ILL:   e = mk(4'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);
      default: e = mk(4'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    endcase
    push(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {name, "/ID"});
    if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
    tk = (k == K_BEQ && zz) || (k == K_BNE && !zz);
    push(mk(ac, as_, bs, ez, 1'b0, 1'b0, 1'b0, 1'b0, tk, tk ? 2'd1 : 2'd0, 1'b0, 2'd0, 2'd0, 1'b0),
         1'($urandom_range(0, 1)), zz, {name, "/EXE"});
    if (k == K_BEQ || k == K_BNE) return;
    if (k == K_LW || k == K_SW) begin
      e = mk(4'd0, 2'd0, 2'd0, 1'b0, k == K_LW, k == K_SW, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
      for (int i = 0; i < mw; i++) push(e, 1'b0, 1'($urandom_range(0, 1)), {name, "/MEMwait"});
      push(e, 1'b1, 1'($urandom_range(0, 1)), {name, "/MEM"});
      if (k == K_SW) return;
    end
    push(mk(4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1,
            (k == K_R) ? 2'd1 : 2'd0, (k == K_LW) ? 2'd1 : 2'd0, 1'b0),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {name, "/WB"});
  endtask

  // Drive and check up to n queued cycles (n < 0: all), then drop the rest
  task automatic play(input int n);
    int cnt = 0;
    while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
      mem_ready = mr_q.pop_front();
      z = z_q.pop_front();
      @(negedge clock);
      check(tag_q.pop_front(), obs, exp_q.pop_front());
      @(posedge clock);
      #1;
      cnt++;
    end
    exp_q.delete();
    mr_q.delete();
    z_q.delete();
    tag_q.delete();
  endtask

  initial begin
    logic [5:0] ro, rf;
    resetn = 1'b0; op = 6'b100011; func = 6'b000000; z = 1'b1; mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("reset_hold", obs, 22'd0);
    end
    @(posedge clock); #1;
    resetn = 1'b1;

    build(6'b000000, 6'b100000, 1'b0, 2, 0, "add");  play(-1);
    build(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_z1"); play(-1);
    build(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_z0"); play(-1);
    build(6'b000101, 6'b000000, 1'b0, 1, 0, "bne_z0"); play(-1);
    build(6'b000101, 6'b000000, 1'b1, 0, 0, "bne_z1"); play(-1);
    build(6'b100011, 6'b000000, 1'b0, 0, 3, "lw");   play(-1);
    build(6'b101011, 6'b000000, 1'b0, 0, 2, "sw");   play(-1);
    build(6'b000000, 6'b000000, 1'b0, 0, 0, "sll");  play(-1);
    build(6'b000000, 6'b000011, 1'b0, 0, 0, "sra");  play(-1);
    build(6'b001111, 6'b000000, 1'b0, 0, 0, "lui");  play(-1);
    build(6'b001100, 6'b000000, 1'b0, 0, 0, "andi"); play(-1);
    build(6'b111111, 6'b000000, 1'b0, 0, 0, "ill_op"); play(-1);
    build(6'b000000, 6'b111111, 1'b0, 0, 0, "ill_fn"); play(-1);
    build(6'b000011, 6'b000000, 1'b0, 0, 0, "jal");  play(-1);
    build(6'b000010, 6'b000000, 1'b0, 1, 0, "j");    play(-1);
    build(6'b000000, 6'b001000, 1'b0, 0, 0, "jr");   play(-1);

    // lw aborted by reset while MEM is waiting
    build(6'b100011, 6'b000000, 1'b0, 0, 10, "lw_abort");
    play(5);
    mem_ready = 1'b0;
    resetn = 1'b0;
    #1 check("reset_async", obs, 22'd0);
    @(negedge clock);
    check("reset_mid_mem", obs, 22'd0);
    @(posedge clock); #1;
    check("reset_after_edge", obs, 22'd0);
    resetn = 1'b1;
    build(6'b000000, 6'b100010, 1'b0, 1, 0, "after_reset"); play(-1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ro = 6'($urandom); rf = 6'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        ro = 6'b000000; rf = fn_tab[$urandom_range(0, 8)];
      end else begin
        ro = op_tab[$urandom_range(0, 10)]; rf = 6'($urandom);
      end
      build(ro, rf, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
            $sformatf("rnd%0d_op%b_fn%b", n, ro, rf));
      play(-1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
